// File: rtl/reg_bank.sv
// CSR bank with byte strobes, read-only mask, hardware update ports and error-flagged
// write/read responses. Both channels take one request per cycle and answer one cycle later.
module reg_bank #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]            RO_MASK   = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          waddr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    input  logic                           bready,
    output logic [DATA_WIDTH-1:0]          bdata,
    output logic                           bvalid,
    output logic                           berr,
    input  logic [ADDR_WIDTH-1:0]          raddr,
    input  logic                           arvalid,
    output logic                           aready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           rvalid,
    input  logic                           rready,
    output logic                           rerr,
    input  logic [NUM_REGS-1:0]            hw_we,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
    output logic [NUM_REGS-1:0]            sw_wr_pulse
);

    localparam int NBYTES = DATA_WIDTH / 8;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_nxt;
    logic [NUM_REGS-1:0]                 whit;
    logic [NUM_REGS-1:0]                 rhit;
    logic [NUM_REGS-1:0]                 wsel;
    logic [DATA_WIDTH-1:0]               bdata_nxt;
    logic [DATA_WIDTH-1:0]               rdata_nxt;
    logic                                w_ok;
    logic                                r_ok;
    logic                                wacc;
    logic                                racc;

    assign wready = !bvalid || bready;
    assign aready = !rvalid || rready;
    assign wacc   = wvalid && wready;
    assign racc   = arvalid && aready;
    assign regs_q = regs;

    // Per-register decode avoids indexing RO_MASK/regs with out-of-range addresses.
    always_comb begin
        whit      = '0;
        rhit      = '0;
        wsel      = '0;
        reg_nxt   = regs;
        bdata_nxt = '0;
        rdata_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            whit[i] = (waddr == ADDR_WIDTH'(i));
            rhit[i] = (raddr == ADDR_WIDTH'(i));
            wsel[i] = wacc && whit[i] && !RO_MASK[i];
            if (hw_we[i])
                reg_nxt[i] = hw_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            if (wsel[i]) begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (wstrb[k])
                        reg_nxt[i][k*8 +: 8] = wdata[k*8 +: 8];
                end
            end
            if (wsel[i])
                bdata_nxt = reg_nxt[i];
            if (rhit[i])
                rdata_nxt = regs[i];
        end
        w_ok = |(whit & ~RO_MASK);
        r_ok = |rhit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs        <= RESET_VAL;
            bvalid      <= 1'b0;
            bdata       <= '0;
            berr        <= 1'b0;
            rvalid      <= 1'b0;
            rdata       <= '0;
            rerr        <= 1'b0;
            sw_wr_pulse <= '0;
        end else begin
            regs        <= reg_nxt;
            sw_wr_pulse <= wsel;

            if (wacc) begin
                bvalid <= 1'b1;
                bdata  <= w_ok ? bdata_nxt : '0;
                berr   <= !w_ok;
            end else if (bready) begin
                bvalid <= 1'b0;
            end

            if (racc) begin
                rvalid <= 1'b1;
                rdata  <= r_ok ? rdata_nxt : '0;
                rerr   <= !r_ok;
            end else if (rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: tasks push expected responses, a monitor pops them
// on each response handshake; direct checks cover reset, backpressure and regs_q.
module tb_reg_bank;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam logic [NR-1:0]    RO = 16'h0001;
    localparam logic [NR*DW-1:0] RV = {{((NR-2)*DW){1'b0}}, 32'hCAFEF00D, 32'h0};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     waddr = '0;
    logic [DW-1:0]     wdata = '0;
    logic [DW/8-1:0]   wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic              bready = 1'b1;
    logic [DW-1:0]     bdata;
    logic              bvalid;
    logic              berr;
    logic [AW-1:0]     raddr = '0;
    logic              arvalid = 1'b0;
    logic              aready;
    logic [DW-1:0]     rdata;
    logic              rvalid;
    logic              rready = 1'b1;
    logic              rerr;
    logic [NR-1:0]     hw_we = '0;
    logic [NR*DW-1:0]  hw_wdata = '0;
    logic [NR*DW-1:0]  regs_q;
    logic [NR-1:0]     sw_wr_pulse;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        logic [NR-1:0] p;
    } bexp_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
    } rexp_t;

    bexp_t bq[$];
    rexp_t rq[$];

    reg_bank #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .rst(rst),
        .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bready(bready), .bdata(bdata), .bvalid(bvalid), .berr(berr),
        .raddr(raddr), .arvalid(arvalid), .aready(aready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready), .rerr(rerr),
        .hw_we(hw_we), .hw_wdata(hw_wdata), .regs_q(regs_q), .sw_wr_pulse(sw_wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] slice(input int i);
        return regs_q[i*DW +: DW];
    endfunction

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                            input logic [DW-1:0] ed, input logic ee, input logic [NR-1:0] ep);
        bexp_t x;
        int n = 0;
        waddr = a; wdata = d; wstrb = s; wvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!wready && n < 100);
        if (!wready) begin
            errors++; checks++;
            $display("FAIL write_timeout: wready stuck low for addr %0d", a);
        end
        x.d = ed; x.e = ee; x.p = ep;
        bq.push_back(x);
        @(posedge clk); #1;
        wvalid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] ed, input logic ee);
        rexp_t x;
        int n = 0;
        raddr = a; arvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!aready && n < 100);
        if (!aready) begin
            errors++; checks++;
            $display("FAIL read_timeout: aready stuck low for addr %0d", a);
        end
        x.d = ed; x.e = ee;
        rq.push_back(x);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    // Monitor: pulse checked on the first cycle of each write response, data on handshake.
    initial begin : monitor
        bit b_first = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                b_first = 1'b1;
            end else begin
                if (bvalid) begin
                    if (bq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL b_unexpected: bvalid=1 bdata=0x%08h with nothing expected", bdata);
                    end else begin
                        if (b_first)
                            check("sw_wr_pulse", DW'(sw_wr_pulse), DW'(bq[0].p));
                        if (bready) begin
                            check("bdata", bdata, bq[0].d);
                            check("berr", DW'(berr), DW'(bq[0].e));
                            void'(bq.pop_front());
                            b_first = 1'b1;
                        end else begin
                            b_first = 1'b0;
                        end
                    end
                end
                if (rvalid && rready) begin
                    if (rq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL r_unexpected: rvalid=1 rdata=0x%08h with nothing expected", rdata);
                    end else begin
                        check("rdata", rdata, rq[0].d);
                        check("rerr", DW'(rerr), DW'(rq[0].e));
                        void'(rq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #12;
        check("rst_bvalid", DW'(bvalid), 0);
        check("rst_rvalid", DW'(rvalid), 0);
        check("rst_pulse", DW'(sw_wr_pulse), 0);
        check("rst_bdata", bdata, 0);
        check("rst_reg1", slice(1), 32'hCAFEF00D);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("rst_wready", DW'(wready), 1);
        check("rst_aready", DW'(aready), 1);

        // write / readback
        do_write(3, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0, 16'h0008);
        do_read(3, 32'hDEADBEEF, 1'b0);
        do_read(1, 32'hCAFEF00D, 1'b0);

        // byte strobes
        do_write(2, 32'h11223344, 4'hF, 32'h11223344, 1'b0, 16'h0004);
        do_write(2, 32'hAABBCCDD, 4'h5, 32'h11BB33DD, 1'b0, 16'h0004);
        check("regs_q_strobe", slice(2), 32'h11BB33DD);
        do_write(2, 32'hFFFFFFFF, 4'h0, 32'h11BB33DD, 1'b0, 16'h0004);

        // errors
        do_write(20, 32'h12345678, 4'hF, 32'h0, 1'b1, 16'h0000);
        check("oor_no_change", slice(3), 32'hDEADBEEF);
        do_read(31, 32'h0, 1'b1);
        do_write(0, 32'h12345678, 4'hF, 32'h0, 1'b1, 16'h0000);
        check("ro_unchanged", slice(0), 32'h0);
        do_read(0, 32'h0, 1'b0);

        // write backpressure
        bready = 1'b0;
        do_write(4, 32'h00000011, 4'hF, 32'h00000011, 1'b0, 16'h0010);
        @(negedge clk);
        check("bp_wready", DW'(wready), 0);
        check("bp_bdata_hold", bdata, 32'h00000011);
        fork
            do_write(6, 32'h00000022, 4'hF, 32'h00000022, 1'b0, 16'h0040);
            begin
                repeat (3) @(posedge clk);
                #1 bready = 1'b1;
            end
        join
        check("bp_second_write", slice(6), 32'h00000022);

        // read backpressure
        rready = 1'b0;
        do_read(4, 32'h00000011, 1'b0);
        @(negedge clk);
        check("bp_aready", DW'(aready), 0);
        check("bp_rdata_hold", rdata, 32'h00000011);
        fork
            do_read(6, 32'h00000022, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1 rready = 1'b1;
            end
        join

        // collision: read old, SW byte 0 beats hardware, hardware fills other bytes
        @(posedge clk); #1;
        raddr = 5; arvalid = 1'b1;
        waddr = 5; wdata = 32'h000000FF; wstrb = 4'h1; wvalid = 1'b1;
        hw_we = 16'h0020; hw_wdata[5*DW +: DW] = 32'h12345678;
        rq.push_back('{d: 32'h0, e: 1'b0});
        bq.push_back('{d: 32'h123456FF, e: 1'b0, p: 16'h0020});
        @(posedge clk); #1;
        arvalid = 1'b0; wvalid = 1'b0; hw_we = '0;
        check("collision_reg5", slice(5), 32'h123456FF);
        do_read(5, 32'h123456FF, 1'b0);

        // read-only register: hardware wins over a same-cycle SW write
        waddr = 0; wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
        hw_we = 16'h0001; hw_wdata[0 +: DW] = 32'h00000055;
        bq.push_back('{d: 32'h0, e: 1'b1, p: 16'h0000});
        @(posedge clk); #1;
        wvalid = 1'b0; hw_we = '0;
        check("ro_hw_wins", slice(0), 32'h00000055);

        // reset with both responses pending
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        waddr = 7; wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
        raddr = 3; arvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0; arvalid = 1'b0;
        check("pre_rst_valids", DW'({bvalid, rvalid}), 3);
        #2 rst = 1'b1;
        #1;
        check("async_bvalid", DW'(bvalid), 0);
        check("async_rvalid", DW'(rvalid), 0);
        check("rst_reg3", slice(3), 32'h0);
        check("rst_reg1_again", slice(1), 32'hCAFEF00D);
        check("rst_reg7", slice(7), 32'h0);
        @(negedge clk); rst = 1'b0;
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", DW'({wready, aready}), 3);
        do_write(9, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5, 1'b0, 16'h0200);
        do_read(9, 32'hA5A5A5A5, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("bq_drained", DW'(bq.size()), 0);
        check("rq_drained", DW'(rq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
